plru_set_tracker: RTL and testbench

//  Multi-set tree-PLRU replacement tracker for set-associative caches/TLBs: one (NumWays-1)-bit tree per set.
//  Hit port marks ways used; request/response port returns a victim way per set (invalid ways preferred).

---
 rtl/plru_pkg.sv | 40 ++++
 rtl/plru_victim_sel.sv | 85 ++++++++
 rtl/plru_set_tracker.sv | 180 ++++++++++++++++++
 tb/tb_plru_set_tracker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plru_pkg.sv
// ============================================================================
//  Module  : plru_pkg
//  Brief   : Shared types, constants and tree-path helpers for the tree-PLRU
//            set tracker.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package plru_pkg;

    localparam int unsigned c_def_sets   = 64;
    localparam int unsigned c_def_ways   = 8;
    localparam int unsigned c_def_tree_w = c_def_ways - 1;

    typedef logic [$clog2(c_def_ways)-1:0] way_idx_t;
    typedef logic [$clog2(c_def_sets)-1:0] set_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RSP   = 2'd1,
        ST_FLUSH = 2'd2
    } plru_state_e;

    // Node visited at depth lvl on the root-to-leaf path of a way.
    function automatic int unsigned path_node(input int unsigned way,
                                              input int unsigned lvl,
                                              input int unsigned levels);
        return ((32'd1 << lvl) - 32'd1) + (way >> (levels - lvl));
    endfunction

    // Direction taken at depth lvl (0 = left, 1 = right), MSB of way first.
    function automatic logic path_bit(input int unsigned way,
                                      input int unsigned lvl,
                                      input int unsigned levels);
        return ((way >> (levels - 32'd1 - lvl)) & 32'd1) != 32'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/plru_victim_sel.sv
// ============================================================================
//  Module  : plru_victim_sel
//  Brief   : Combinational victim picker: lowest eligible invalid way, else a
//            walk of the PLRU tree. Lock masking is built with PLRU_LOCK_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module plru_victim_sel
    import plru_pkg::*;
#(
    parameter int unsigned NumWays = 8
) (
    input  logic [NumWays-2:0] tree_i,
    input  logic [NumWays-1:0] valid_ways_i,
    input  logic [NumWays-1:0] lock_i,
    output logic [NumWays-1:0] way_o,
    output logic               err_o
);

    localparam int unsigned c_levels = $clog2(NumWays);

    logic [NumWays-1:0] w_free;

`ifdef PLRU_LOCK_EN
    assign w_free = ~valid_ways_i & ~lock_i;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^lock_i;
    assign w_free        = ~valid_ways_i;
`endif

    always_comb begin
        logic        found;
        logic        dir;
        int unsigned node;
        int unsigned prefix;
`ifdef PLRU_LOCK_EN
        logic        left_lk;
        logic        right_lk;
`endif
        way_o  = '0;
        err_o  = 1'b0;
        found  = 1'b0;
        dir    = 1'b0;
        node   = 0;
        prefix = 0;
        for (int i = 0; i < NumWays; i++) begin
            if (!found && w_free[i]) begin
                way_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        if (!found) begin
            for (int unsigned l = 0; l < c_levels; l++) begin
`ifdef PLRU_LOCK_EN
                // A fully locked child is never entered, whatever the node bit says.
                left_lk  = 1'b1;
                right_lk = 1'b1;
                for (int unsigned w = 0; w < NumWays; w++) begin
                    if ((w >> (c_levels - 1 - l)) == 2 * prefix)
                        left_lk = left_lk & lock_i[w];
                    if ((w >> (c_levels - 1 - l)) == 2 * prefix + 1)
                        right_lk = right_lk & lock_i[w];
                end
                dir = left_lk ? 1'b1 : (right_lk ? 1'b0 : tree_i[node]);
`else
                dir = tree_i[node];
`endif
                node   = 2 * node + (dir ? 32'd2 : 32'd1);
                prefix = 2 * prefix + (dir ? 32'd1 : 32'd0);
            end
            way_o[prefix] = 1'b1;
`ifdef PLRU_LOCK_EN
            if (&lock_i) begin
                way_o = '0;
                err_o = 1'b1;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/plru_set_tracker.sv
// ============================================================================
//  Module  : plru_set_tracker
//  Brief   : Multi-set tree-PLRU tracker with touch port, victim req/rsp port
//            and sequential flush. Optional lock support: PLRU_LOCK_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module plru_set_tracker
    import plru_pkg::*;
#(
    parameter  int unsigned NumSets  = 64,
    parameter  int unsigned NumWays  = 8,
    localparam int unsigned c_set_w  = (NumSets > 1) ? $clog2(NumSets) : 1,
    localparam int unsigned c_way_w  = $clog2(NumWays),
    localparam int unsigned c_tree_w = NumWays - 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    output logic               busy_o,
    input  logic               touch_valid_i,
    input  logic [c_set_w-1:0] touch_set_i,
    input  logic [c_way_w-1:0] touch_way_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [c_set_w-1:0] req_set_i,
    input  logic [NumWays-1:0] req_valid_ways_i,
    input  logic [NumWays-1:0] req_lock_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [NumWays-1:0] rsp_way_o,
    output logic               rsp_err_o
);

    localparam int unsigned c_levels = $clog2(NumWays);

    plru_state_e         r_state;
    logic [c_set_w-1:0]  r_flush_cnt;
    logic                r_rsp_valid;
    logic [NumWays-1:0]  r_rsp_way;
    logic                r_rsp_err;
    logic [c_set_w-1:0]  r_rsp_set;
    logic [c_way_w-1:0]  r_rsp_bin;
    logic [c_tree_w-1:0] r_tree     [NumSets];
    logic [c_tree_w-1:0] w_tree_nxt [NumSets];

    logic                w_accept;
    logic                w_auto_en;
    logic                w_touch_en;
    logic [c_tree_w-1:0] w_sel_tree;
    logic [NumWays-1:0]  w_sel_way;
    logic                w_sel_err;
    logic [c_way_w-1:0]  w_sel_bin;

    function automatic logic [c_tree_w-1:0] f_touch(input logic [c_tree_w-1:0] tree,
                                                    input logic [c_way_w-1:0]  way);
        logic [c_tree_w-1:0] t;
        t = tree;
        for (int unsigned l = 0; l < c_levels; l++)
            t[path_node(32'(way), l, c_levels)] = ~path_bit(32'(way), l, c_levels);
        return t;
    endfunction

    assign req_ready_o = ((r_state == ST_IDLE) && !flush_i) ||
                         ((r_state == ST_RSP) && rsp_ready_i);
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_auto_en   = (r_state == ST_RSP) && rsp_ready_i && !r_rsp_err;
    assign w_touch_en  = touch_valid_i && (r_state != ST_FLUSH);
    assign busy_o      = (r_state == ST_FLUSH);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_way_o   = r_rsp_way;
    assign rsp_err_o   = r_rsp_err;

    // Auto-touch first so the external touch wins on shared nodes.
    always_comb begin
        for (int s = 0; s < NumSets; s++) begin
            w_tree_nxt[s] = r_tree[s];
            if (w_auto_en && (r_rsp_set == c_set_w'(s)))
                w_tree_nxt[s] = f_touch(w_tree_nxt[s], r_rsp_bin);
            if (w_touch_en && (touch_set_i == c_set_w'(s)))
                w_tree_nxt[s] = f_touch(w_tree_nxt[s], touch_way_i);
            if ((r_state == ST_FLUSH) && (r_flush_cnt == c_set_w'(s)))
                w_tree_nxt[s] = '0;
        end
    end

    assign w_sel_tree = w_tree_nxt[req_set_i];

    plru_victim_sel #(
        .NumWays (NumWays)
    ) u_victim_sel (
        .tree_i       (w_sel_tree),
        .valid_ways_i (req_valid_ways_i),
        .lock_i       (req_lock_i),
        .way_o        (w_sel_way),
        .err_o        (w_sel_err)
    );

    always_comb begin
        w_sel_bin = '0;
        for (int i = 0; i < NumWays; i++)
            if (w_sel_way[i]) w_sel_bin = c_way_w'(i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NumSets; s++) r_tree[s] <= '0;
        end else begin
            for (int s = 0; s < NumSets; s++) r_tree[s] <= w_tree_nxt[s];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_way   <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_set   <= '0;
            r_rsp_bin   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (flush_i) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= '0;
                    end else if (w_accept) begin
                        r_state     <= ST_RSP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_way   <= w_sel_way;
                        r_rsp_err   <= w_sel_err;
                        r_rsp_set   <= req_set_i;
                        r_rsp_bin   <= w_sel_bin;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        if (w_accept) begin
                            r_rsp_way <= w_sel_way;
                            r_rsp_err <= w_sel_err;
                            r_rsp_set <= req_set_i;
                            r_rsp_bin <= w_sel_bin;
                        end else begin
                            r_rsp_valid <= 1'b0;
                            if (flush_i) begin
                                r_state     <= ST_FLUSH;
                                r_flush_cnt <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == c_set_w'(NumSets - 1))
                        r_state <= ST_IDLE;
                    else
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_onehot_way: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(rsp_way_o));
    a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid_o && !rsp_ready_i) |=>
            (rsp_valid_o && $stable(rsp_way_o) && $stable(rsp_err_o)));
    a_pow2_params: assert property (@(posedge clk_i)
        ((NumSets & (NumSets - 1)) == 0) && ((NumWays & (NumWays - 1)) == 0) &&
        (NumSets >= 1) && (NumWays >= 2));
`endif

endmodule

`default_nettype wire

// File: tb/tb_plru_set_tracker.sv
// ============================================================================
//  Module  : tb_plru_set_tracker
//  Brief   : Vector-table and scoreboard bench for plru_set_tracker (4 sets,
//            8 ways); lock cases are built with PLRU_LOCK_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_plru_set_tracker;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       busy_o;
    logic       touch_valid_i;
    logic [1:0] touch_set_i;
    logic [2:0] touch_way_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [1:0] req_set_i;
    logic [7:0] req_valid_ways_i;
    logic [7:0] req_lock_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [7:0] rsp_way_o;
    logic       rsp_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [7:0] way;
        logic       err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit         touch_en;
        int         tset;
        int         tway;
        int         rset;
        logic [7:0] vw;
        logic [7:0] exp_way;
    } vec_t;
    vec_t vecs[12];

    plru_set_tracker #(.NumSets(4), .NumWays(8)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .busy_o           (busy_o),
        .touch_valid_i    (touch_valid_i),
        .touch_set_i      (touch_set_i),
        .touch_way_i      (touch_way_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_set_i        (req_set_i),
        .req_valid_ways_i (req_valid_ways_i),
        .req_lock_i       (req_lock_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_way_o        (rsp_way_o),
        .rsp_err_o        (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Responses are compared on the falling edge preceding their handshake.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got way %0h, expected no response", rsp_way_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_way", 32'(rsp_way_o), 32'(e.way));
                check("rsp_err", 32'(rsp_err_o), 32'(e.err));
            end
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic touch(input int s, input int w);
        touch_valid_i = 1'b1;
        touch_set_i   = s[1:0];
        touch_way_i   = w[2:0];
        tick();
        touch_valid_i = 1'b0;
    endtask

    task automatic do_req(input int s, input logic [7:0] vw, input logic [7:0] lk,
                          input logic [7:0] exp_way, input logic exp_err);
        int waitc = 0;
        while (!req_ready_o && waitc < 20) begin
            tick();
            waitc++;
        end
        if (!req_ready_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: got req_ready_o 0, expected 1");
        end else begin
            req_valid_i      = 1'b1;
            req_set_i        = s[1:0];
            req_valid_ways_i = vw;
            req_lock_i       = lk;
            sb.push_back('{exp_way, exp_err});
            tick();
            req_valid_i = 1'b0;
            req_lock_i  = 8'h00;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 0, 0, 2, 8'hFF, 8'h01};
        vecs[1]  = '{0, 0, 0, 2, 8'hFF, 8'h10};
        vecs[2]  = '{1, 1, 0, 1, 8'hFF, 8'h10};
        vecs[3]  = '{1, 1, 4, 1, 8'hFF, 8'h04};
        vecs[4]  = '{0, 0, 0, 0, 8'hFB, 8'h04};
        vecs[5]  = '{0, 0, 0, 0, 8'hFF, 8'h10};
        vecs[6]  = '{0, 0, 0, 0, 8'h00, 8'h01};
        vecs[7]  = '{0, 0, 0, 0, 8'h7F, 8'h80};
        vecs[8]  = '{0, 0, 0, 0, 8'hFF, 8'h08};
        vecs[9]  = '{0, 0, 0, 3, 8'hFF, 8'h01};
        vecs[10] = '{1, 3, 2, 3, 8'hFF, 8'h10};
        vecs[11] = '{0, 0, 0, 3, 8'hFF, 8'h02};

        rst_ni = 1'b0; flush_i = 1'b0; touch_valid_i = 1'b0; touch_set_i = '0;
        touch_way_i = '0; req_valid_i = 1'b0; req_set_i = '0; req_valid_ways_i = '0;
        req_lock_i = '0; rsp_ready_i = 1'b1;
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("reset_rsp_way",   32'(rsp_way_o),   32'd0);
        check("reset_rsp_err",   32'(rsp_err_o),   32'd0);
        check("reset_busy",      32'(busy_o),      32'd0);
        check("reset_req_ready", 32'(req_ready_o), 32'd1);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].touch_en) touch(vecs[i].tset, vecs[i].tway);
            do_req(vecs[i].rset, vecs[i].vw, 8'h00, vecs[i].exp_way, 1'b0);
        end

        // Touch in the acceptance cycle is seen by the selection.
        touch_valid_i = 1'b1; touch_set_i = 2'd2; touch_way_i = 3'd0;
        req_valid_i = 1'b1; req_set_i = 2'd2; req_valid_ways_i = 8'hFF;
        sb.push_back('{8'h40, 1'b0});
        tick();
        touch_valid_i = 1'b0; req_valid_i = 1'b0;
        tick();

        // Back-pressure with touches to the response's set.
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_set_i = 2'd2; req_valid_ways_i = 8'hFF;
        sb.push_back('{8'h04, 1'b0});
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            touch_valid_i = 1'b1; touch_set_i = 2'd2; touch_way_i = 3'd2;
            check("stall_valid", 32'(rsp_valid_o), 32'd1);
            check("stall_way",   32'(rsp_way_o),   32'h04);
            tick();
        end
        touch_valid_i = 1'b0;
        rsp_ready_i   = 1'b1;
        tick();
        do_req(2, 8'hFF, 8'h00, 8'h20, 1'b0);

        // Back-to-back on one set: second pick sees the first auto-touch.
        req_valid_i = 1'b1; req_set_i = 2'd0; req_valid_ways_i = 8'hFF;
        sb.push_back('{8'h20, 1'b0});
        tick();
        check("b2b_ready", 32'(req_ready_o), 32'd1);
        sb.push_back('{8'h02, 1'b0});
        tick();
        req_valid_i = 1'b0;
        tick();

        // Flush: one-cycle pulse, set-by-set clear, touches dropped meanwhile.
        touch(3, 7);
        flush_i = 1'b1;
        #1;
        check("flush_req_ready", 32'(req_ready_o), 32'd0);
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            touch_valid_i = 1'b1; touch_set_i = 2'd0; touch_way_i = 3'd0;
            check("flush_busy",  32'(busy_o),      32'd1);
            check("flush_ready", 32'(req_ready_o), 32'd0);
            tick();
        end
        touch_valid_i = 1'b0;
        check("flush_done_busy",  32'(busy_o),      32'd0);
        check("flush_done_ready", 32'(req_ready_o), 32'd1);
        do_req(0, 8'hFF, 8'h00, 8'h01, 1'b0);
        do_req(3, 8'hFF, 8'h00, 8'h01, 1'b0);

        // Reset while a response is pending.
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_set_i = 2'd1; req_valid_ways_i = 8'hFF;
        tick();
        req_valid_i = 1'b0;
        check("pending_valid", 32'(rsp_valid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("async_reset_valid", 32'(rsp_valid_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        tick();
        do_req(1, 8'hFF, 8'h00, 8'h01, 1'b0);

`ifdef PLRU_LOCK_EN
        do_req(0, 8'hFF, 8'h0F, 8'h10, 1'b0);
        do_req(0, 8'hFF, 8'hFF, 8'h00, 1'b1);
        do_req(0, 8'hFF, 8'h00, 8'h01, 1'b0);
`endif

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
